// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings and constants for the seq_generator / seg_detector link
package seq_pkg;

    localparam int SEQ_PAT_W = 4;
    localparam int SEQ_CNT_W = 4;

    // Pattern the lab top loads into both the generator and the detector
    localparam logic [SEQ_PAT_W-1:0] LAB_PATTERN = 4'b1011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        GAP   = ST_GAP,
        DONE  = ST_DONE
    } seq_state_t;

endpackage

// File: rtl/seq_generator_if.sv
// rtl/seq_generator_if.sv - control and serial-output bundle of seq_generator
import seq_pkg::*;

interface seq_generator_if #(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int CNT_W = SEQ_CNT_W
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic [CNT_W-1:0] gap;
    logic             P1;
    logic             valid;
    logic             busy;
    logic             done;

    // Controlling logic side
    modport master (
        output start, abort, pattern, reps, gap,
        input  P1, valid, busy, done
    );

    // Generator side
    modport slave (
        input  start, abort, pattern, reps, gap,
        output P1, valid, busy, done
    );
endinterface

// File: rtl/seq_piso.sv
// rtl/seq_piso.sv - parallel-in serial-out shift register, MSB first
module seq_piso #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb_next
);
    logic [PAT_W-1:0] q;

    // MSB the register will hold after this edge; lets the caller register P1 in step with state
    always_comb begin
        msb_next = q[PAT_W-1];
        if (load) begin
            msb_next = din[PAT_W-1];
        end else if (shift) begin
            msb_next = q[PAT_W-2];
        end
    end

    // Load has priority over shift; shifted-in bits are zero
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[PAT_W-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_generator.sv
// rtl/seq_generator.sv - bit-serial pattern transmitter with repeat count and inter-repeat gap
module seq_generator
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int CNT_W = SEQ_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    seq_generator_if.slave bus
);
    localparam int BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    seq_state_t       state, state_nxt;
    logic [PAT_W-1:0] pat_r, pat_r_nxt;
    logic [CNT_W-1:0] gap_r, gap_r_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;

    logic             piso_load;
    logic             piso_shift;
    logic [PAT_W-1:0] piso_din;
    logic             piso_msb_next;

    logic p1_q, valid_q, busy_q, done_q;
    logic p1_nxt, valid_nxt, busy_nxt, done_nxt;

    seq_piso #(.PAT_W(PAT_W)) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (piso_load),
        .shift    (piso_shift),
        .din      (piso_din),
        .msb_next (piso_msb_next)
    );

    // Next-state, counter and shifter control; outputs are derived from the state being entered
    always_comb begin
        state_nxt   = state;
        pat_r_nxt   = pat_r;
        gap_r_nxt   = gap_r;
        rep_cnt_nxt = rep_cnt;
        gap_cnt_nxt = gap_cnt;
        bit_cnt_nxt = bit_cnt;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        piso_din    = pat_r;

        case (state)
            IDLE: begin
                // abort alongside start cancels the request
                if (bus.start && !bus.abort) begin
                    pat_r_nxt   = bus.pattern;
                    gap_r_nxt   = bus.gap;
                    rep_cnt_nxt = bus.reps;
                    gap_cnt_nxt = '0;
                    if (bus.reps == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt   = SHIFT;
                        bit_cnt_nxt = BIT_LAST;
                        piso_load   = 1'b1;
                        piso_din    = bus.pattern;
                    end
                end
            end

            SHIFT: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (bit_cnt != '0) begin
                    piso_shift  = 1'b1;
                    bit_cnt_nxt = bit_cnt - BIT_W'(1);
                end else begin
                    if (rep_cnt != '0) begin
                        rep_cnt_nxt = rep_cnt - CNT_W'(1);
                    end
                    if (rep_cnt <= CNT_W'(1)) begin
                        state_nxt = DONE;
                    end else if (gap_r == '0) begin
                        // back-to-back repeat: reload without a bubble
                        piso_load   = 1'b1;
                        bit_cnt_nxt = BIT_LAST;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = gap_r;
                    end
                end
            end

            GAP: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (gap_cnt <= CNT_W'(1)) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = SHIFT;
                    piso_load   = 1'b1;
                    bit_cnt_nxt = BIT_LAST;
                end else begin
                    gap_cnt_nxt = gap_cnt - CNT_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        valid_nxt = (state_nxt == SHIFT);
        p1_nxt    = valid_nxt & piso_msb_next;
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
    end

    // State, captured request, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_r   <= '0;
            gap_r   <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            p1_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pat_r   <= pat_r_nxt;
            gap_r   <= gap_r_nxt;
            rep_cnt <= rep_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            p1_q    <= p1_nxt;
            valid_q <= valid_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.P1    = p1_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_seq_generator.sv
// tb/tb_seq_generator.sv - directed self-checking bench for seq_generator
module tb_seq_generator;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_generator_if #(.PAT_W(4), .CNT_W(4)) bus ();

    seq_generator #(.PAT_W(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] p1_s, v_s, b_s, d_s;
    logic [3:0]  win;
    int          hits;
    int          busy_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        p1_s     = '0;
        v_s      = '0;
        b_s      = '0;
        d_s      = '0;
        win      = '0;
        hits     = 0;
        busy_cnt = 0;
    endtask

    // Sample the current cycle (first sample ends up in the higher bit), then advance
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            p1_s = {p1_s[30:0], bus.P1};
            v_s  = {v_s[30:0], bus.valid};
            b_s  = {b_s[30:0], bus.busy};
            d_s  = {d_s[30:0], bus.done};
            win  = {win[2:0], bus.P1};
            if (win == LAB_PATTERN) hits++;
            if (bus.busy) busy_cnt++;
            step();
        end
    endtask

    task automatic launch(input logic [3:0] pat, input logic [3:0] r, input logic [3:0] g);
        bus.pattern = pat;
        bus.reps    = r;
        bus.gap     = g;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = '0;
        bus.reps    = '0;
        bus.gap     = '0;
        step();
        step();
        check("rst_p1",    {31'd0, bus.P1},    32'd0);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},  32'd0);
        check("rst_done",  {31'd0, bus.done},  32'd0);
        rst = 1'b0;
        step();

        // Single repeat
        clr();
        launch(4'b1011, 4'd1, 4'd0);
        collect(6);
        check("t1_p1",    p1_s, 32'b101100);
        check("t1_valid", v_s,  32'b111100);
        check("t1_busy",  b_s,  32'b111110);
        check("t1_done",  d_s,  32'b000010);

        // Two repeats back-to-back
        clr();
        launch(4'b1011, 4'd2, 4'd0);
        collect(10);
        check("t2_p1",    p1_s, 32'b1011101100);
        check("t2_valid", v_s,  32'b1111111100);
        check("t2_busy",  b_s,  32'b1111111110);
        check("t2_done",  d_s,  32'b0000000010);

        // Two repeats with gap 2; inputs scrambled after capture
        clr();
        launch(4'b1011, 4'd2, 4'd2);
        bus.pattern = 4'b0000;
        bus.reps    = 4'd7;
        bus.gap     = 4'd0;
        collect(12);
        check("t3_p1",    p1_s, 32'b101100101100);
        check("t3_valid", v_s,  32'b111100111100);
        check("t3_busy",  b_s,  32'b111111111110);
        check("t3_done",  d_s,  32'b000000000010);

        // reps == 0
        clr();
        launch(4'b1011, 4'd0, 4'd0);
        collect(3);
        check("t4_p1",    p1_s, 32'b000);
        check("t4_valid", v_s,  32'b000);
        check("t4_busy",  b_s,  32'b100);
        check("t4_done",  d_s,  32'b100);

        // start while busy is ignored
        clr();
        launch(4'b1011, 4'd1, 4'd0);
        collect(1);
        bus.pattern = 4'b0000;
        bus.start   = 1'b1;
        collect(1);
        bus.start   = 1'b0;
        collect(4);
        check("t5a_p1",   p1_s, 32'b101100);
        check("t5a_busy", b_s,  32'b111110);
        check("t5a_done", d_s,  32'b000010);

        // abort mid-shift
        clr();
        launch(4'b1011, 4'd1, 4'd0);
        collect(1);
        bus.abort = 1'b1;
        collect(1);
        bus.abort = 1'b0;
        collect(4);
        check("t5b_p1",    p1_s, 32'b100000);
        check("t5b_valid", v_s,  32'b110000);
        check("t5b_busy",  b_s,  32'b110000);
        check("t5b_done",  d_s,  32'b000000);

        // reset mid-shift
        clr();
        launch(4'b1011, 4'd1, 4'd0);
        collect(1);
        rst = 1'b1;
        collect(1);
        rst = 1'b0;
        collect(4);
        check("t5c_p1",   p1_s, 32'b100000);
        check("t5c_busy", b_s,  32'b110000);
        check("t5c_done", d_s,  32'b000000);

        // abort together with start in IDLE suppresses the start
        clr();
        bus.abort = 1'b1;
        launch(4'b1011, 4'd1, 4'd0);
        bus.abort = 1'b0;
        collect(3);
        check("t5d_busy",  b_s, 32'b000);
        check("t5d_valid", v_s, 32'b000);

        // Loopback against a sliding-window detector on the lab pattern
        clr();
        launch(LAB_PATTERN, 4'd3, 4'd1);
        collect(18);
        check("t6_hits",     32'(hits),     32'd3);
        check("t6_busy_cnt", 32'(busy_cnt), 32'd15);
        check("t6_done",     d_s,           32'b000000000000001000);
        check("t6_p1",       p1_s,          32'b101101011010110000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
